// File: rtl/retro16_pkg.sv
// retro16_pkg: shared definitions for the Retro16 front end.
//   - default reset PC and interrupt vector
//   - opcode constants used by fetch/decode
//   - fetch FSM state encoding and the fetch queue entry type
package retro16_pkg;

  localparam logic [15:0] DEFAULT_RESET_PC   = 16'h0000;
  localparam logic [15:0] DEFAULT_IRQ_VECTOR = 16'h0100;

  // OP_NOP is what the decoder sees while nothing is valid; OP_RETI is the
  // end-interrupt instruction whose execution raises int_ret.
  localparam logic [15:0] OP_NOP  = 16'h0000;
  localparam logic [15:0] OP_RETI = 16'h0001;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,  // no request outstanding
    FS_REQ   = 2'd1,  // request outstanding, data will be kept
    FS_DRAIN = 2'd2   // request outstanding, data will be discarded
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } fetch_entry_t;

  // Sequential successor of a fetch address; wraps FFFF -> 0000.
  function automatic logic [15:0] pc_next(input logic [15:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of {instr, pc} between fetch and decode.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   push, push_entry write an entry (accepted when not full, or full with pop)
//   pop              remove the head (ignored when empty)
//   flush            empty the queue; wins over push and pop
//   head_entry       current head (contents undefined-but-stable when empty)
//   count/full/empty occupancy
module fetch_queue
  import retro16_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head_entry,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t slot_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign empty      = (count_q == 2'd0);
  assign full       = (count_q == 2'd2);
  assign count      = count_q;
  assign head_entry = slot_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        slot_q[wr_ptr_q] <= push_entry;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: Retro16 instruction fetch stage.
// Owns the fetch PC, issues single-word reads to instruction memory, buffers
// up to two fetched words and hands them to decode in order. Handles branch
// redirects, interrupt entry and interrupt return.
//
// Handshakes (valid/ready):
//   memory: mem_read/mem_addr are held stable until the cycle mem_ready is
//           high; the read completes in that cycle with mem_data valid.
//   decode: the head {instruction, instr_pc} transfers on a rising edge where
//           instr_valid && instr_ready; instr_valid never depends on
//           instr_ready.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   mem_addr, mem_read            instruction memory request
//   mem_data, mem_ready           instruction memory response
//   instruction, instr_pc,
//   instr_valid, instr_ready      decode interface
//   redirect_valid, redirect_pc   taken branch / PC write from execute
//   irq, int_ret                  interrupt request level, return pulse
//   in_service, epc               interrupt status and saved return address
//   state_dbg                     current fetch FSM state
module fetch_unit
  import retro16_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [15:0] IRQ_VECTOR = DEFAULT_IRQ_VECTOR
) (
  input  logic         clk,
  input  logic         reset_n,
  output logic [15:0]  mem_addr,
  output logic         mem_read,
  input  logic [15:0]  mem_data,
  input  logic         mem_ready,
  output logic [15:0]  instruction,
  output logic [15:0]  instr_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         redirect_valid,
  input  logic [15:0]  redirect_pc,
  input  logic         irq,
  input  logic         int_ret,
  output logic         in_service,
  output logic [15:0]  epc,
  output fetch_state_e state_dbg
);

  fetch_state_e state_q, state_d;
  logic [15:0]  fetch_pc_q, fetch_pc_d;
  logic [15:0]  drain_addr_q, drain_addr_d;
  logic [15:0]  epc_q, epc_d;
  logic         in_service_q, in_service_d;

  logic         q_push;
  logic         q_pop;
  logic         q_flush;
  fetch_entry_t q_push_entry;
  fetch_entry_t q_head;
  logic [1:0]   q_count;
  logic         q_full;
  logic         q_empty;

  logic         ctrl_event;
  logic [15:0]  ctrl_target;
  logic         outstanding;
  logic [2:0]   count_after;

  fetch_queue u_queue (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (q_push),
    .push_entry (q_push_entry),
    .pop        (q_pop),
    .flush      (q_flush),
    .head_entry (q_head),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty)
  );

  // Decode-side view: zeros while the queue is empty.
  assign instr_valid = !q_empty;
  assign instruction = q_empty ? OP_NOP : q_head.instr;
  assign instr_pc    = q_empty ? 16'h0000 : q_head.pc;

  // During DRAIN fetch_pc already holds the new target, so the abandoned
  // request's address is kept separately to keep mem_addr stable.
  assign mem_read  = (state_q != FS_IDLE);
  assign mem_addr  = (state_q == FS_DRAIN) ? drain_addr_q : fetch_pc_q;
  assign in_service = in_service_q;
  assign epc        = epc_q;
  assign state_dbg  = state_q;

  assign outstanding  = (state_q != FS_IDLE);
  assign q_pop        = instr_valid && instr_ready;
  assign q_push_entry = '{instr: mem_data, pc: fetch_pc_q};

  // Occupancy after this cycle's push (one word) and pop.
  assign count_after = {1'b0, q_count} + 3'd1 - {2'b00, q_pop};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FS_IDLE;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= 16'h0000;
      epc_q        <= 16'h0000;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      epc_q        <= epc_d;
      in_service_q <= in_service_d;
    end
  end

  // Control event selection: redirect > int_ret > irq entry.
  always_comb begin
    ctrl_event   = 1'b0;
    ctrl_target  = fetch_pc_q;
    epc_d        = epc_q;
    in_service_d = in_service_q;
    if (redirect_valid) begin
      ctrl_event  = 1'b1;
      ctrl_target = redirect_pc;
    end else if (int_ret) begin
      ctrl_event   = 1'b1;
      ctrl_target  = epc_q;
      in_service_d = 1'b0;
    end else if (irq && !in_service_q) begin
      ctrl_event   = 1'b1;
      ctrl_target  = IRQ_VECTOR;
      in_service_d = 1'b1;
      // The oldest not-yet-decoded address is where execution resumes.
      epc_d        = q_empty ? fetch_pc_q : q_head.pc;
    end
  end

  // Fetch FSM next state and queue controls.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    q_push       = 1'b0;
    q_flush      = 1'b0;
    if (ctrl_event) begin
      q_flush    = 1'b1;
      fetch_pc_d = ctrl_target;
      if (outstanding && !mem_ready) begin
        state_d = FS_DRAIN;
        // A second event while draining keeps the original address.
        if (state_q == FS_REQ) begin
          drain_addr_d = fetch_pc_q;
        end
      end else begin
        // Any completing read is stale; the queue is empty next cycle.
        state_d = FS_REQ;
      end
    end else begin
      case (state_q)
        FS_IDLE: begin
          if (!q_full || q_pop) begin
            state_d = FS_REQ;
          end
        end
        FS_REQ: begin
          if (mem_ready) begin
            q_push     = 1'b1;
            fetch_pc_d = pc_next(fetch_pc_q);
            state_d    = (count_after < 3'd2) ? FS_REQ : FS_IDLE;
          end
        end
        FS_DRAIN: begin
          if (mem_ready) begin
            state_d = FS_REQ;
          end
        end
        default: state_d = FS_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the Retro16 core, directly upstream of the decoder. It owns the fetch PC and issues word reads to instruction memory through a ready-based handshake. Fetched instructions are buffered in a 2-entry queue and presented, with their address, to the decode stage. It also handles branch redirects from execute and interrupt entry and return.

## Interface
- `RESET_PC`, default 16'h0000: first fetch address after reset.
- `IRQ_VECTOR`, default 16'h0100: fetch address on interrupt entry.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `mem_addr` output 16: instruction memory word address.
- `mem_read` output 1: read request, held until `mem_ready`.
- `mem_data` input 16: read data, valid in the `mem_ready` cycle.
- `mem_ready` input 1: request completes this cycle.
- `instruction` output 16: head-of-queue instruction to the decoder.
- `instr_pc` output 16: address of `instruction`.
- `instr_valid` output 1: `instruction` and `instr_pc` are valid.
- `instr_ready` input 1: decode consumes the head when `instr_valid` is also high.
- `redirect_valid` input 1: taken branch or PC write from execute.
- `redirect_pc` input 16: new fetch address.
- `irq` input 1: level interrupt request.
- `int_ret` input 1: one-cycle pulse; the end-interrupt instruction (16'h0001) has executed.
- `in_service` output 1: interrupt handler is active.
- `epc` output 16: saved return address.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - REQ: `mem_read` high; `mem_addr` and `mem_read` stay stable until `mem_ready`.
  - DRAIN: outstanding request whose data will be discarded.
- IDLE → REQ when free slots exceed the number of outstanding requests (free = 2 − count). At most 1 request is ever outstanding.
- REQ with `mem_ready`:
  - push {`mem_data`, `mem_addr`} into the queue;
  - fetch_pc += 1, wrapping 16'hFFFF → 16'h0000;
  - issue the next request in the same cycle if a slot is free after this cycle's push and pop, else go to IDLE.
- Control events, one per cycle, in priority order: `redirect_valid` > `int_ret` > (`irq` && !`in_service`) > sequential.
- `redirect_valid`:
  - flush the queue and set fetch_pc = `redirect_pc`;
  - if a request is outstanding and `mem_ready` is low, go to DRAIN; when `mem_ready` arrives the data is dropped and the next cycle issues a request to fetch_pc.
- Interrupt entry:
  - `epc` = head `instr_pc` if the queue is non-empty, else fetch_pc;
  - flush the queue, set fetch_pc = `IRQ_VECTOR`, set `in_service` = 1;
  - an outstanding request is handled as for a redirect.
- `irq` is ignored while `in_service`=1. No nesting.
- `int_ret`: flush, fetch_pc = `epc`, `in_service` = 0. When `in_service`=0, `int_ret` is a plain redirect to `epc`.
- A flush and a pop in the same cycle resolve as flush only. Queue order is strictly preserved; no duplicates and no losses.

## Timing
- Reset values while `reset_n`=0:
  - `mem_read`=0, `mem_addr`=`RESET_PC`;
  - `instr_valid`=0, `instruction`=0, `instr_pc`=0;
  - `in_service`=0, `epc`=0;
  - queue empty, FSM in IDLE.
- The first `mem_read` is asserted in the first rising edge after `reset_n` deasserts.
- Latency: with `mem_ready` returned in the request cycle, data pushed at edge N shows as `instr_valid` in cycle N+1 if the queue was empty. Sustained throughput is 1 instruction per cycle.
- With the queue full and `instr_ready`=0, `mem_read` stays low.
- After a control event at edge N with no outstanding request:
  - `mem_addr` = new target from N+1;
  - `instr_valid`=0 from N+1 until the new data returns.
- Reset asserted mid-request drops the request immediately; memory must tolerate an abandoned read.

## Structure
- `retro16_pkg` holds:
  - `RESET_PC` and `IRQ_VECTOR` defaults;
  - opcode constants `OP_NOP` (16'h0000) and `OP_RETI` (16'h0001);
  - the fetch FSM state enum.
- Sub-module `fetch_queue`: 2-entry FIFO of {instr, pc} with push, pop and flush, plus count, full and empty outputs. Flush has priority over push/pop.

## Test plan
- Reset and stream: `mem_ready`=1, `instr_ready`=1, memory[i]=16'hA000+i → `mem_read` in the first cycle after reset; instructions 16'hA000, 16'hA001, 16'hA002 with `instr_pc` 0, 1, 2 on consecutive cycles.
- Backpressure: `instr_ready`=0 for 6 cycles → 2 entries held, `mem_read` low; on release the sequence continues in order with no gap or duplicate.
- Redirect mid-request: `mem_ready` delayed 3 cycles, `redirect_valid` with `redirect_pc`=16'h0040 in cycle 1 → stale data never reaches `instr_valid`; the next `mem_addr` is 16'h0040 and `instr_pc` is 16'h0040.
- Interrupt round trip: `irq` with head `instr_pc`=16'h0010 → `mem_addr`=16'h0100, `in_service`=1, `epc`=16'h0010; a second `irq` is ignored; `int_ret` → fetch 16'h0010, `in_service`=0.
- Simultaneous events: `redirect_valid` (16'h0200) and `irq` in the same cycle → redirect wins; `irq` is taken next cycle with `epc`=16'h0200.
- Reset mid-operation: `reset_n` low with 2 entries queued and a request outstanding → all outputs take reset values asynchronously; fetch restarts at `RESET_PC`.
